// File: rtl/jk_bank_arbiter.sv
// Round-robin arbiter that shares a bank of W JK flip-flops between NREQ requesters.
// Stage A grants one requester per edge; stage B applies the registered J/K drive.
module jk_bank_arbiter #(
   parameter int NREQ = 4,
   parameter int W    = 8,
   parameter int AW   = 3,
   parameter int CW   = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NREQ-1:0]      req,
   input  logic [2*NREQ-1:0]    op,
   input  logic [AW*NREQ-1:0]   addr,
   output logic [NREQ-1:0]      gnt,
   output logic [W-1:0]         q,
   output logic [W-1:0]         q_bar,
   output logic [CW-1:0]        cmd_cnt,
   output logic                 err
);

   localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

   logic [PW-1:0]   ptr_p0;
   logic [PW-1:0]   ptr_nxt;
   logic            found_p0;
   logic [NREQ-1:0] gnt_nxt;
   logic [1:0]      op_sel;
   logic [AW-1:0]   addr_sel;
   int              c_idx;

   logic            vld_p1;
   logic [1:0]      op_p1;
   logic [AW-1:0]   addr_p1;
   logic [W-1:0]    q_nxt;
   logic            in_range_p1;

   function automatic logic jk_next(input logic qc, input logic [1:0] jk);
      case (jk)
         2'b00:   return qc;
         2'b01:   return 1'b0;
         2'b10:   return 1'b1;
         default: return ~qc;
      endcase
   endfunction

   // Stage A: first requester at or after the pointer, wrapping modulo NREQ
   always_comb begin
      found_p0 = 1'b0;
      gnt_nxt  = '0;
      op_sel   = '0;
      addr_sel = '0;
      ptr_nxt  = ptr_p0;
      c_idx    = 0;
      for (int o = 0; o < NREQ; o++) begin
         c_idx = int'(ptr_p0) + o;
         if (c_idx >= NREQ) c_idx = c_idx - NREQ;
         if (!found_p0 && req[c_idx]) begin
            found_p0       = 1'b1;
            gnt_nxt[c_idx] = 1'b1;
            op_sel         = op[2*c_idx +: 2];
            addr_sel       = addr[AW*c_idx +: AW];
            ptr_nxt        = (c_idx == NREQ-1) ? '0 : PW'(c_idx + 1);
         end
      end
   end

   // Stage B: only the addressed flop sees the JK drive; out-of-range indices touch nothing
   always_comb begin
      q_nxt       = q;
      in_range_p1 = 1'b0;
      for (int k = 0; k < W; k++) begin
         if (addr_p1 == AW'(k)) begin
            in_range_p1 = 1'b1;
            q_nxt[k]    = jk_next(q[k], op_p1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ptr_p0  <= '0;
         gnt     <= '0;
         vld_p1  <= 1'b0;
         q       <= '0;
         cmd_cnt <= '0;
         err     <= 1'b0;
      end else begin
         gnt    <= gnt_nxt;
         vld_p1 <= found_p0;
         if (found_p0) ptr_p0 <= ptr_nxt;
         if (vld_p1) begin
            cmd_cnt <= cmd_cnt + CW'(1);
            if (in_range_p1) q   <= q_nxt;
            else             err <= 1'b1;
         end
      end
   end

   // Command payload is qualified by vld_p1, so it needs no reset
   always_ff @(posedge clk) begin
      if (found_p0) begin
         op_p1   <= op_sel;
         addr_p1 <= addr_sel;
      end
   end

   assign q_bar = ~q;

endmodule
